// File: rtl/vga_controller_if.sv
// Display-timing bundle from the VGA timing generator to the pixel/colour generator.
interface vga_controller_if;
  logic       hsync;
  logic       vsync;
  logic [9:0] x;
  logic [9:0] y;

  modport master (output hsync, output vsync, output x, output y);
  modport slave  (input  hsync, input  vsync, input  x, input  y);
endinterface

// File: rtl/vga_controller.sv
// VGA timing generator: free-running pixel/line counters with active-low
// hsync/vsync decoded from the registered coordinate.
module vga_controller #(
  parameter int HACTIVE = 640,
  parameter int HFP     = 16,
  parameter int HSYNC   = 96,
  parameter int HBP     = 48,
  parameter int VACTIVE = 480,
  parameter int VFP     = 10,
  parameter int VSYNC   = 2,
  parameter int VBP     = 33
) (
  input  logic              vgaclk,
  input  logic              reset,
  vga_controller_if.master  vga
);

  localparam int HTOTAL = HACTIVE + HFP + HSYNC + HBP;
  localparam int VTOTAL = VACTIVE + VFP + VSYNC + VBP;

  localparam logic [9:0] HLAST = 10'(HTOTAL - 1);
  localparam logic [9:0] VLAST = 10'(VTOTAL - 1);

  // Sync window bounds are 11 bits: the exclusive end may land exactly on 1024.
  localparam logic [10:0] HS_START = 11'(HACTIVE + HFP);
  localparam logic [10:0] HS_END   = 11'(HACTIVE + HFP + HSYNC);
  localparam logic [10:0] VS_START = 11'(VACTIVE + VFP);
  localparam logic [10:0] VS_END   = 11'(VACTIVE + VFP + VSYNC);

  logic [9:0] x;
  logic [9:0] y;

  always_ff @(posedge vgaclk or negedge reset) begin
    if (!reset) begin
      x <= '0;
      y <= '0;
    end else if (x == HLAST) begin
      x <= '0;
      y <= (y == VLAST) ? '0 : y + 10'd1;
    end else begin
      x <= x + 10'd1;
    end
  end

  // Syncs are decoded from the registered counters so they line up with the pixel shown.
  assign vga.x     = x;
  assign vga.y     = y;
  assign vga.hsync = ~(({1'b0, x} >= HS_START) && ({1'b0, x} < HS_END));
  assign vga.vsync = ~(({1'b0, y} >= VS_START) && ({1'b0, y} < VS_END));

endmodule

// File: tb/tb_vga_controller.sv
// Bench for vga_controller: directed coordinate/sync vectors, sync-width scan,
// asynchronous reset, and a full-frame check on a short-frame instance.
module tb_vga_controller;

  logic vgaclk  = 1'b0;
  logic reset   = 1'b0;
  logic reset_s = 1'b0;

  int total = 0;
  int bad   = 0;

  vga_controller_if vga();
  vga_controller_if vga_s();

  vga_controller dut (
    .vgaclk (vgaclk),
    .reset  (reset),
    .vga    (vga)
  );

  // Short frame: VTOTAL = 35 lines, vsync low on lines 30..31, 28000 clocks per frame.
  vga_controller #(
    .VACTIVE (20),
    .VFP     (10),
    .VSYNC   (2),
    .VBP     (3)
  ) dut_s (
    .vgaclk (vgaclk),
    .reset  (reset_s),
    .vga    (vga_s)
  );

  always #5 vgaclk = ~vgaclk;

  typedef struct {
    int   n;
    int   ex;
    int   ey;
    logic ehs;
    logic evs;
  } vec_t;

  vec_t tbl[$];

  task automatic tick();
    @(posedge vgaclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int ex, input int ey, input logic ehs, input logic evs);
    chk({tag, ".x"},     32'(vga.x),     32'(ex));
    chk({tag, ".y"},     32'(vga.y),     32'(ey));
    chk({tag, ".hsync"}, 32'(vga.hsync), 32'(ehs));
    chk({tag, ".vsync"}, 32'(vga.vsync), 32'(evs));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   edges;
    int   lows;
    int   fall_x;
    int   rise_x;
    logic prev;
    int   budget;
    int   vlows;
    int   vmin;
    int   vmax;
    int   xmax;
    int   ymax;

    tbl.push_back('{1,    1,   0,  1'b1, 1'b1});
    tbl.push_back('{2,    2,   0,  1'b1, 1'b1});
    tbl.push_back('{3,    3,   0,  1'b1, 1'b1});
    tbl.push_back('{42,   42,  0,  1'b1, 1'b1});
    tbl.push_back('{655,  655, 0,  1'b1, 1'b1});
    tbl.push_back('{656,  656, 0,  1'b0, 1'b1});
    tbl.push_back('{751,  751, 0,  1'b0, 1'b1});
    tbl.push_back('{752,  752, 0,  1'b1, 1'b1});
    tbl.push_back('{799,  799, 0,  1'b1, 1'b1});
    tbl.push_back('{800,  0,   1,  1'b1, 1'b1});
    tbl.push_back('{801,  1,   1,  1'b1, 1'b1});
    tbl.push_back('{1456, 656, 1,  1'b0, 1'b1});
    tbl.push_back('{1552, 752, 1,  1'b1, 1'b1});
    tbl.push_back('{8042, 42,  10, 1'b1, 1'b1});

    // Reset held for two edges.
    repeat (2) tick();
    chk_all("reset_hold", 0, 0, 1'b1, 1'b1);

    @(negedge vgaclk);
    reset = 1'b1;
    edges = 0;

    foreach (tbl[i]) begin
      while (edges < tbl[i].n) begin
        tick();
        edges++;
      end
      chk_all($sformatf("vec%0d", tbl[i].n), tbl[i].ex, tbl[i].ey, tbl[i].ehs, tbl[i].evs);
    end

    // Scan one full line (y=11) for the hsync pulse shape.
    while (edges % 800 != 0) begin
      tick();
      edges++;
    end
    lows   = 0;
    fall_x = -1;
    rise_x = -1;
    prev   = vga.hsync;
    for (int i = 0; i < 800; i++) begin
      if (vga.hsync === 1'b0) lows++;
      if (prev === 1'b1 && vga.hsync === 1'b0) fall_x = int'(vga.x);
      if (prev === 1'b0 && vga.hsync === 1'b1) rise_x = int'(vga.x);
      prev = vga.hsync;
      tick();
      edges++;
    end
    chk("hsync_low_count", 32'(lows),   32'd96);
    chk("hsync_fall_x",    32'(fall_x), 32'd656);
    chk("hsync_rise_x",    32'(rise_x), 32'd752);
    chk_all("after_scan", 0, 12, 1'b1, 1'b1);

    // Asynchronous reset between edges at (300,12).
    budget = 2000;
    while (!(vga.x == 10'd300 && vga.y == 10'd12) && budget > 0) begin
      tick();
      budget--;
    end
    chk("reach_300_12", 32'(budget > 0), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk_all("async_reset", 0, 0, 1'b1, 1'b1);
    repeat (2) tick();
    chk_all("reset_held_again", 0, 0, 1'b1, 1'b1);

    @(negedge vgaclk);
    reset = 1'b1;
    repeat (42) tick();
    chk_all("restart42", 42, 0, 1'b1, 1'b1);

    // Reset while hsync is low must force it high at once.
    budget = 2000;
    while (vga.x != 10'd700 && budget > 0) begin
      tick();
      budget--;
    end
    chk("reach_700", 32'(budget > 0), 32'd1);
    chk("hsync_at_700", 32'(vga.hsync), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    chk_all("async_reset_in_sync", 0, 0, 1'b1, 1'b1);
    @(negedge vgaclk);
    reset = 1'b1;

    // Full frame on the short-frame instance.
    @(negedge vgaclk);
    reset_s = 1'b1;
    vlows = 0;
    vmin  = 1000;
    vmax  = -1;
    xmax  = 0;
    ymax  = 0;
    for (int n = 1; n <= 28000; n++) begin
      tick();
      if (n < 28000) begin
        if (vga_s.vsync === 1'b0) begin
          vlows++;
          if (int'(vga_s.y) < vmin) vmin = int'(vga_s.y);
          if (int'(vga_s.y) > vmax) vmax = int'(vga_s.y);
        end
        if (int'(vga_s.x) > xmax) xmax = int'(vga_s.x);
        if (int'(vga_s.y) > ymax) ymax = int'(vga_s.y);
      end
      if (n == 27999) begin
        chk("frame_last.x", 32'(vga_s.x), 32'd799);
        chk("frame_last.y", 32'(vga_s.y), 32'd34);
      end
    end
    chk("frame_wrap.x",     32'(vga_s.x),     32'd0);
    chk("frame_wrap.y",     32'(vga_s.y),     32'd0);
    chk("frame_wrap.vsync", 32'(vga_s.vsync), 32'd1);
    chk("vsync_low_count",  32'(vlows),       32'd1600);
    chk("vsync_first_line", 32'(vmin),        32'd30);
    chk("vsync_last_line",  32'(vmax),        32'd31);
    chk("x_max",            32'(xmax),        32'd799);
    chk("y_max",            32'(ymax),        32'd34);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
